bin_loader: RTL
===============

BIN_LOADER -- requirements
Module: bin_loader

Interface
REQ-001 Parameter: RUBOUT_IGNORE, default 1, meaning: when 1, byte 0xFF is discarded in every state.
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse that arms the loader.
REQ-005 Port: rx_data  in  8  tape byte, valid only with rx_valid.
REQ-006 Port: rx_valid  in  1  byte present this cycle; a byte is consumed when rx_valid and rx_ready are both 1.
REQ-007 Port: rx_ready  out  1  loader accepts bytes; high while armed.
REQ-008 Port: wr_data  out  12  word to core memory write port.
REQ-009 Port: wr_addr  out  12  core address for wr_data.
REQ-010 Port: wr_en  out  1  one-cycle write strobe to core memory.
REQ-011 Port: busy  out  1  high from leader detection until done.
REQ-012 Port: done  out  1  level; load finished; cleared by start.
REQ-013 Port: cksum_err  out  1  valid when done=1; checksum mismatch.
REQ-014 Port: frame_err  out  1  sticky; malformed frame seen; cleared by start.

Function
REQ-015 Tape format SHALL be PDP-8 BIN: leader/trailer byte 0x80; field-setting bytes (bits 7:6 = 11) ignored; frames are two bytes, high 6 bits then low 6 bits.
REQ-016 Frame first byte with bit 6 set SHALL denote an origin; bit 6 clear SHALL denote data.
REQ-017 States SHALL be IDLE, LEADER, HI, LO, DONE.
REQ-018 IDLE: rx_ready=0; start moves to LEADER and clears done, cksum_err, frame_err, sum and the pending-frame flag.
REQ-019 LEADER: 0x80 bytes are consumed; first non-0x80, non-ignored byte is taken as HI byte of frame and moves to LO.
REQ-020 HI: 0x80 while a pending frame exists moves to DONE (trailer); 0x80 with no pending frame stays in HI.
REQ-021 LO: byte with bit 7 or bit 6 set SHALL set frame_err, drop the partial frame, return to HI.
REQ-022 A completed frame SHALL be held as pending; the previous pending frame is committed in the cycle after the new frame's LO byte is consumed.
REQ-023 Commit of origin SHALL load the address register with {hi[5:0],lo[5:0]}; commit of data SHALL pulse wr_en with wr_addr = address and wr_data = word, then increment the address modulo 4096 (0xFFF wraps to 0x000).
REQ-024 Commit SHALL add both raw frame bytes (origin bit 6 included) to a 12-bit sum, modulo 4096.
REQ-025 On trailer, the pending frame SHALL NOT be written or summed; cksum_err = (pending word != sum) and done=1 one cycle after trailer consumption.
REQ-026 Pending origin at trailer SHALL be compared as a checksum in the same way.
REQ-027 DONE: rx_ready=0, busy=0, done=1; start re-arms to LEADER.
REQ-028 start while busy SHALL abort the load: return to LEADER, drop pending frame, issue no further writes.
REQ-029 rx_valid with rx_ready=0 SHALL be ignored with no state change.

Reset
REQ-030 Reset SHALL force IDLE; wr_en, busy, done, cksum_err, frame_err, rx_ready = 0; wr_addr, wr_data, sum, address = 0.
REQ-031 Reset asserted mid-load SHALL suppress any wr_en from that cycle onward.

Structure
REQ-032 Shared package SHALL hold the state enum and constants LEADER_BYTE=0x80, RUBOUT_BYTE=0xFF, FIELD_MASK=0xC0.
REQ-033 Single module, no sub-modules; outputs connect directly to core memory write port (data, wraddress, wren).

Verification
REQ-034 start; bytes 80,80,42,00,3C,02,02,00,80 -> one wr_en, addr 0x080, data 0xF02; done=1, cksum_err=0.
REQ-035 As REQ-034 with checksum bytes 02,01 -> no extra write, done=1, cksum_err=1.
REQ-036 Origin 7777 octal (7F,3F) then two data frames then correct checksum -> writes to 0xFFF then 0x000.
REQ-037 Data HI byte followed by 0x45 in LO -> frame_err=1, no write for that frame, load continues.
REQ-038 Reset asserted after fourth byte of REQ-034 -> no wr_en, all outputs 0, rx_ready=0 until start.
REQ-039 FF and C0 interleaved into REQ-034 stream -> identical result to REQ-034.

Source files
------------

// File: rtl/bin_loader_pkg.sv
// bin_loader_pkg
//   Shared definitions for the PDP-8 BIN tape loader: loader states, tape
//   byte constants and the helper that assembles a 12-bit word from the
//   two 6-bit halves of a frame.
package bin_loader_pkg;

    localparam int DATA_W = 12;  // PDP-8 word / address width
    localparam int BYTE_W = 8;   // tape byte width

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        HI,
        LO,
        DONE
    } state_t;

    localparam logic [BYTE_W-1:0] LEADER_BYTE = 8'h80;
    localparam logic [BYTE_W-1:0] RUBOUT_BYTE = 8'hFF;
    localparam logic [BYTE_W-1:0] FIELD_MASK  = 8'hC0;

    // A frame carries the high six bits first, then the low six bits.
    function automatic logic [DATA_W-1:0] frame_word(input logic [5:0] hi6,
                                                     input logic [5:0] lo6);
        return {hi6, lo6};
    endfunction

endpackage

// File: rtl/bin_loader.sv
// bin_loader
//   Reads a PDP-8 BIN format paper tape byte stream and writes the decoded
//   words into core memory.  Each two-byte frame is held as "pending" until
//   the next frame completes; only then is it committed (origin load or data
//   write plus checksum accumulation).  The frame still pending when the
//   trailer arrives is the checksum and is compared against the running sum.
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high
//   start      one-cycle pulse: arm the loader (also aborts a load in progress)
//   rx_data    tape byte
//   rx_valid   tape byte present; consumed when rx_valid && rx_ready
//   rx_ready   loader is armed and accepting bytes
//   wr_data    word for the core memory write port
//   wr_addr    address for wr_data
//   wr_en      one-cycle write strobe
//   busy       load in progress (from leader until done)
//   done       load finished; cleared by start
//   cksum_err  checksum mismatch, valid while done=1
//   frame_err  sticky malformed-frame flag; cleared by start
module bin_loader
    import bin_loader_pkg::*;
#(
    parameter int RUBOUT_IGNORE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              cksum_err,
    output logic              frame_err
);

    state_t state, next_state;

    logic [BYTE_W-1:0] hi_byte;     // first byte of the frame being received
    logic [BYTE_W-1:0] pend_hi;     // raw bytes of the completed, uncommitted frame
    logic [BYTE_W-1:0] pend_lo;
    logic              pend_valid;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] pend_word;

    logic ignored;
    logic take;
    logic is_leader;

    // Events decoded by the FSM and acted on by the datapath register block.
    logic latch_hi;
    logic frame_done;
    logic bad_lo;
    logic trailer;
    logic arm_busy;

    // Rubouts and field-setting bytes never reach the frame logic.
    assign ignored   = ((RUBOUT_IGNORE != 0) && (rx_data == RUBOUT_BYTE)) ||
                       ((rx_data & FIELD_MASK) == FIELD_MASK);
    assign rx_ready  = (state == LEADER) || (state == HI) || (state == LO);
    assign take      = rx_valid && rx_ready && !ignored;
    assign is_leader = (rx_data == LEADER_BYTE);
    assign pend_word = frame_word(pend_hi[5:0], pend_lo[5:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch_hi   = 1'b0;
        frame_done = 1'b0;
        bad_lo     = 1'b0;
        trailer    = 1'b0;
        arm_busy   = 1'b0;

        if (start) begin
            // Arms from idle/done and aborts any load in progress.
            next_state = LEADER;
        end else begin
            case (state)
                LEADER: begin
                    if (take) begin
                        arm_busy = 1'b1;
                        if (!is_leader) begin
                            latch_hi   = 1'b1;
                            next_state = LO;
                        end
                    end
                end
                HI: begin
                    if (take) begin
                        if (is_leader) begin
                            // Leader bytes before any complete frame are harmless.
                            if (pend_valid) begin
                                trailer    = 1'b1;
                                next_state = DONE;
                            end
                        end else begin
                            latch_hi   = 1'b1;
                            next_state = LO;
                        end
                    end
                end
                LO: begin
                    if (take) begin
                        next_state = HI;
                        if (rx_data[7] || rx_data[6]) begin
                            bad_lo = 1'b1;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end
                end
                default: ;  // IDLE and DONE wait for start
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cksum_err  <= 1'b0;
            frame_err  <= 1'b0;
            sum        <= '0;
            address    <= '0;
            hi_byte    <= '0;
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                busy       <= 1'b0;
                done       <= 1'b0;
                cksum_err  <= 1'b0;
                frame_err  <= 1'b0;
                sum        <= '0;
                pend_valid <= 1'b0;
            end else begin
                if (arm_busy) begin
                    busy <= 1'b1;
                end
                if (latch_hi) begin
                    hi_byte <= rx_data;
                end
                if (bad_lo) begin
                    frame_err <= 1'b1;
                end
                if (frame_done) begin
                    // New frame becomes pending; the previous one is committed.
                    pend_hi    <= hi_byte;
                    pend_lo    <= rx_data;
                    pend_valid <= 1'b1;
                    if (pend_valid) begin
                        sum <= sum + {{(DATA_W-BYTE_W){1'b0}}, pend_hi}
                                   + {{(DATA_W-BYTE_W){1'b0}}, pend_lo};
                        if (pend_hi[6]) begin
                            address <= pend_word;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= address;
                            wr_data <= pend_word;
                            address <= address + 12'd1;
                        end
                    end
                end
                if (trailer) begin
                    // The frame left pending at the trailer is the checksum.
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    cksum_err  <= (pend_word != sum);
                    pend_valid <= 1'b0;
                end
            end
        end
    end

endmodule
